// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the ROM program counter, resolves NOP delays and JMP locally,
// and hands decoded fields to execute. Define IFU_SINGLE_STEP_EN to add the iStep fetch gate.
module instruction_fetch_unit #(
    parameter logic [15:0] P_RESET_PC = 16'd0,
    parameter logic [7:0]  P_OP_NOP   = 8'd0,
    parameter logic [7:0]  P_OP_JMP   = 8'd1
) (
    input  logic        Clock,
    input  logic        Reset,
`ifdef IFU_SINGLE_STEP_EN
    input  logic        iStep,
`endif
    output logic [15:0] oInstructionAddress,
    input  logic [27:0] iInstruction,
    input  logic        iReady,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oValid,
    output logic [7:0]  oOperation,
    output logic [7:0]  oDestination,
    output logic [7:0]  oSourceA,
    output logic [7:0]  oSourceB,
    output logic [15:0] oLiteral,
    output logic        oDelayActive
);

    localparam int unsigned PC_W    = 16;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned CNT_W   = 24;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DELAY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PC_W-1:0]      r_pc;
    logic                 r_valid;
    logic [FIELD_W-1:0]   r_operation;
    logic [FIELD_W-1:0]   r_destination;
    logic [FIELD_W-1:0]   r_source_a;
    logic [FIELD_W-1:0]   r_source_b;
    logic [CNT_W-1:0]     r_count;

    logic [FIELD_W-1:0]   w_opcode;
    logic [CNT_W-1:0]     w_nop_len;
    logic [PC_W-1:0]      w_pc_inc;
    logic                 w_is_nop;
    logic                 w_is_jmp;
    logic                 w_step;
    logic                 w_slot_free;
    logic                 w_decode;

`ifdef IFU_SINGLE_STEP_EN
    assign w_step = iStep;
`else
    assign w_step = 1'b1;
`endif

    assign w_opcode    = FIELD_W'(iInstruction[27:24]);
    assign w_nop_len   = iInstruction[23:0];
    assign w_pc_inc    = r_pc + PC_W'(1);
    assign w_is_nop    = (w_opcode == P_OP_NOP);
    assign w_is_jmp    = (w_opcode == P_OP_JMP);
    assign w_slot_free = !r_valid || iReady;
    assign w_decode    = (r_state == S_FETCH) && w_slot_free && w_step;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirects always win; a NOP with a nonzero literal is the only way into DELAY.
    always_comb begin
        w_state_next = r_state;
        if (iBranchTaken) begin
            w_state_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: if (w_decode && w_is_nop && (w_nop_len != '0)) w_state_next = S_DELAY;
                S_DELAY: if (r_count <= CNT_W'(1)) w_state_next = S_FETCH;
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        oDelayActive = (r_state == S_DELAY);
    end

    // NOP and JMP retire here without ever reaching execute.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc          <= P_RESET_PC;
            r_valid       <= 1'b0;
            r_operation   <= '0;
            r_destination <= '0;
            r_source_a    <= '0;
            r_source_b    <= '0;
            r_count       <= '0;
        end else if (iBranchTaken) begin
            r_pc    <= iBranchTarget;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (r_state == S_DELAY) begin
            r_count <= r_count - CNT_W'(1);
        end else if (w_decode) begin
            if (w_is_nop) begin
                r_pc    <= w_pc_inc;
                r_valid <= 1'b0;
                r_count <= w_nop_len;
            end else if (w_is_jmp) begin
                r_pc    <= PC_W'(iInstruction[23:16]);
                r_valid <= 1'b0;
            end else begin
                r_pc          <= w_pc_inc;
                r_valid       <= 1'b1;
                r_operation   <= w_opcode;
                r_destination <= iInstruction[23:16];
                r_source_a    <= iInstruction[15:8];
                r_source_b    <= iInstruction[7:0];
            end
        end else if (r_valid && iReady) begin
            r_valid <= 1'b0;
        end
    end

    assign oInstructionAddress = r_pc;
    assign oValid              = r_valid;
    assign oOperation          = r_operation;
    assign oDestination        = r_destination;
    assign oSourceA            = r_source_a;
    assign oSourceB            = r_source_b;
    assign oLiteral            = {r_source_a, r_source_b};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] oInstructionAddress;
    logic [27:0] iInstruction;
    logic        iReady;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oValid;
    logic [7:0]  oOperation;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceA;
    logic [7:0]  oSourceB;
    logic [15:0] oLiteral;
    logic        oDelayActive;
`ifdef IFU_SINGLE_STEP_EN
    logic        iStep = 1'b1;
`endif

    logic [27:0] rom [0:65535];
    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch_unit dut (
        .Clock               (Clock),
        .Reset               (Reset),
`ifdef IFU_SINGLE_STEP_EN
        .iStep               (iStep),
`endif
        .oInstructionAddress (oInstructionAddress),
        .iInstruction        (iInstruction),
        .iReady              (iReady),
        .iBranchTaken        (iBranchTaken),
        .iBranchTarget       (iBranchTarget),
        .oValid              (oValid),
        .oOperation          (oOperation),
        .oDestination        (oDestination),
        .oSourceA            (oSourceA),
        .oSourceB            (oSourceB),
        .oLiteral            (oLiteral),
        .oDelayActive        (oDelayActive)
    );

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oInstructionAddress];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                       input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 65536; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        iReady = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = '0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = mk(4'd0, 8'd0, 8'd0, 8'd50);
        do_reset();
        n_cmp++;
        if ({oValid, oDelayActive, oInstructionAddress, oOperation, oDestination, oLiteral} !== 50'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%b pc=%h op=%h dst=%h lit=%h, expected all zero",
                     oValid, oDelayActive, oInstructionAddress, oOperation, oDestination, oLiteral);
        end
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({oValid, oDelayActive, oInstructionAddress} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_mid_delay: got v=%b d=%b pc=%h, expected 0 0 0000",
                     oValid, oDelayActive, oInstructionAddress);
        end
    endtask

    task automatic test_stream();
        logic [27:0] w;
        clear_rom();
        for (int i = 0; i < 3; i++) rom[i] = mk(4'd2, 8'(i + 1), 8'd1, 8'd3);
        do_reset();
        iReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            w = mk(4'd2, 8'(k + 1), 8'd1, 8'd3);
            n_cmp++;
            if ({oValid, oInstructionAddress, oOperation, oDestination, oSourceA, oSourceB, oLiteral} !==
                {1'b1, 16'(k + 1), 8'd2, w[23:16], w[15:8], w[7:0], w[15:0]}) begin
                n_err++;
                $display("FAIL stream_%0d: got v=%b pc=%h op=%h dst=%h a=%h b=%h lit=%h, expected v=1 pc=%h word=%h",
                         k, oValid, oInstructionAddress, oOperation, oDestination, oSourceA, oSourceB,
                         oLiteral, 16'(k + 1), w);
            end
        end
    endtask

    task automatic test_nop_delay();
        int n_delay = 0;
        int first = 0;
        clear_rom();
        rom[0] = {4'd0, 24'd3};
        rom[1] = mk(4'd2, 8'h5A, 8'd1, 8'd3);
        do_reset();
        iReady = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (oDelayActive) n_delay++;
            if (oValid) begin
                first = e;
                break;
            end
        end
        n_cmp++;
        if (first != 5 || n_delay != 3 || oDestination !== 8'h5A) begin
            n_err++;
            $display("FAIL nop_delay: got first_valid_edge=%0d delay_cycles=%0d dst=%h, expected 5 3 5a",
                     first, n_delay, oDestination);
        end
    endtask

    task automatic test_jmp();
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = mk(4'd3, 8'(i), 8'd0, 8'd0);
        rom[4] = {4'd1, 8'd6, 16'd0};
        rom[5] = mk(4'd3, 8'h55, 8'd0, 8'd0);
        rom[6] = mk(4'd3, 8'h66, 8'd0, 8'd0);
        do_reset();
        iReady = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if ({oValid, oInstructionAddress, oDestination} !== {1'b1, 16'd4, 8'd3}) begin
            n_err++;
            $display("FAIL jmp_before: got v=%b pc=%h dst=%h, expected 1 0004 03",
                     oValid, oInstructionAddress, oDestination);
        end
        tick();
        n_cmp++;
        if ({oValid, oInstructionAddress} !== {1'b0, 16'd6}) begin
            n_err++;
            $display("FAIL jmp_bubble: got v=%b pc=%h, expected 0 0006", oValid, oInstructionAddress);
        end
        tick();
        n_cmp++;
        if ({oValid, oInstructionAddress, oDestination} !== {1'b1, 16'd7, 8'h66}) begin
            n_err++;
            $display("FAIL jmp_target: got v=%b pc=%h dst=%h, expected 1 0007 66",
                     oValid, oInstructionAddress, oDestination);
        end
    endtask

    task automatic test_hold();
        clear_rom();
        rom[0] = mk(4'd2, 8'hA1, 8'h11, 8'h22);
        rom[1] = mk(4'd4, 8'hB2, 8'h33, 8'h44);
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({oValid, oInstructionAddress, oOperation, oDestination, oLiteral} !==
                {1'b1, 16'd1, 8'd2, 8'hA1, 16'h1122}) begin
                n_err++;
                $display("FAIL hold_%0d: got v=%b pc=%h op=%h dst=%h lit=%h, expected 1 0001 02 a1 1122",
                         i, oValid, oInstructionAddress, oOperation, oDestination, oLiteral);
            end
        end
        iReady = 1'b1;
        tick();
        n_cmp++;
        if ({oValid, oInstructionAddress, oOperation, oDestination, oLiteral} !==
            {1'b1, 16'd2, 8'd4, 8'hB2, 16'h3344}) begin
            n_err++;
            $display("FAIL hold_release: got v=%b pc=%h op=%h dst=%h lit=%h, expected 1 0002 04 b2 3344",
                     oValid, oInstructionAddress, oOperation, oDestination, oLiteral);
        end
    endtask

    task automatic test_branch_in_delay();
        clear_rom();
        rom[0] = {4'd0, 24'd100};
        rom[7] = mk(4'd5, 8'h77, 8'd0, 8'd0);
        do_reset();
        iReady = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({oDelayActive, oValid} !== 2'b10) begin
            n_err++;
            $display("FAIL delay_entered: got d=%b v=%b, expected 1 0", oDelayActive, oValid);
        end
        iBranchTaken = 1'b1;
        iBranchTarget = 16'd7;
        tick();
        iBranchTaken = 1'b0;
        n_cmp++;
        if ({oDelayActive, oValid, oInstructionAddress} !== {1'b0, 1'b0, 16'd7}) begin
            n_err++;
            $display("FAIL branch_abort: got d=%b v=%b pc=%h, expected 0 0 0007",
                     oDelayActive, oValid, oInstructionAddress);
        end
        tick();
        n_cmp++;
        if ({oValid, oInstructionAddress, oDestination} !== {1'b1, 16'd8, 8'h77}) begin
            n_err++;
            $display("FAIL branch_fetch: got v=%b pc=%h dst=%h, expected 1 0008 77",
                     oValid, oInstructionAddress, oDestination);
        end
    endtask

    task automatic test_wrap_and_reset();
        clear_rom();
        rom[16'hFFFF] = mk(4'd9, 8'hEE, 8'h12, 8'h34);
        rom[0] = mk(4'd9, 8'h01, 8'h00, 8'h00);
        do_reset();
        iBranchTaken = 1'b1;
        iBranchTarget = 16'hFFFF;
        tick();
        iBranchTaken = 1'b0;
        iReady = 1'b1;
        tick();
        n_cmp++;
        if ({oValid, oInstructionAddress, oDestination, oLiteral} !== {1'b1, 16'h0000, 8'hEE, 16'h1234}) begin
            n_err++;
            $display("FAIL pc_wrap: got v=%b pc=%h dst=%h lit=%h, expected 1 0000 ee 1234",
                     oValid, oInstructionAddress, oDestination, oLiteral);
        end
        iReady = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({oValid, oInstructionAddress, oOperation, oDestination, oLiteral} !== 49'd0) begin
            n_err++;
            $display("FAIL reset_while_valid: got v=%b pc=%h op=%h dst=%h lit=%h, expected all zero",
                     oValid, oInstructionAddress, oOperation, oDestination, oLiteral);
        end
    endtask

    // Reference: instruction-level view where a NOP stalls for its literal and JMP/NOP never issue.
    task automatic test_random();
        logic [15:0] m_pc = 16'd0;
        logic        m_valid = 1'b0;
        logic [27:0] m_word = '0;
        logic [27:0] w;
        int          m_wait = 0;
        int          r;
        for (int i = 0; i < 65536; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      rom[i] = {4'd0, 24'($urandom_range(0, 3))};
            else if (r < 27) rom[i] = {4'd1, 24'($urandom)};
            else             rom[i] = {4'($urandom_range(2, 15)), 24'($urandom)};
        end
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            iReady = ($urandom_range(0, 9) < 7);
            iBranchTaken = ($urandom_range(0, 19) == 0);
            iBranchTarget = 16'($urandom);
            if (iBranchTaken) begin
                m_pc = iBranchTarget;
                m_valid = 1'b0;
                m_wait = 0;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (!m_valid || iReady) begin
                w = rom[m_pc];
                if (w[27:24] == 4'd0) begin
                    m_pc = m_pc + 16'd1;
                    m_valid = 1'b0;
                    m_wait = int'(w[23:0]);
                end else if (w[27:24] == 4'd1) begin
                    m_pc = {8'd0, w[23:16]};
                    m_valid = 1'b0;
                end else begin
                    m_word = w;
                    m_valid = 1'b1;
                    m_pc = m_pc + 16'd1;
                end
            end
            tick();
            n_cmp++;
            if ({oValid, oDelayActive, oInstructionAddress} !== {m_valid, (m_wait > 0), m_pc}) begin
                n_err++;
                $display("FAIL rand_ctl_%0d: got v=%b d=%b pc=%h, expected v=%b d=%b pc=%h",
                         c, oValid, oDelayActive, oInstructionAddress, m_valid, (m_wait > 0), m_pc);
            end
            if (m_valid) begin
                n_cmp++;
                if ({oOperation, oDestination, oSourceA, oSourceB, oLiteral} !==
                    {8'(m_word[27:24]), m_word[23:16], m_word[15:8], m_word[7:0], m_word[15:0]}) begin
                    n_err++;
                    $display("FAIL rand_fields_%0d: got op=%h dst=%h a=%h b=%h lit=%h, expected word %h",
                             c, oOperation, oDestination, oSourceA, oSourceB, oLiteral, m_word);
                end
            end
        end
        iBranchTaken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_nop_delay();
        test_jmp();
        test_hold();
        test_branch_in_delay();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
